// File: rtl/boot_ctrl_wb.sv
// boot_ctrl_wb: watches the UART RX byte stream for a sync/fill/command
// sequence, pulses the core reset, keeps a load window open while bytes
// arrive, and exposes cause/count/control/status on a Wishbone slave port.
module boot_ctrl_wb #(
   parameter int unsigned SYS_CLK_FREQ     = 80000000,
   parameter int unsigned TIMEOUT_SEC      = 2,
   parameter logic [7:0]  SYNC_CHAR        = 8'h2d,
   parameter logic [7:0]  FILL_CHAR        = 8'h5f,
   parameter logic [7:0]  CMD_CHAR         = 8'h70,
   parameter int unsigned RST_PULSE_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic        wb_we_i,
   input  logic [31:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   input  logic [3:0]  wb_sel_i,
   output logic        wb_ack_o,
   output logic [31:0] wb_dat_o,
   output logic        wb_stall_o,
   output logic        wb_err_o,
   input  logic        uart_rx_valid,
   input  logic [7:0]  uart_rx_byte,
   output logic        reset_o,
   output logic        boot_mode_o,
   output logic [1:0]  state_o
);

   localparam int unsigned TIMEOUT_CYCLES = TIMEOUT_SEC * SYS_CLK_FREQ;
   localparam int SIL_W  = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam int PCNT_W = (RST_PULSE_CYCLES < 2) ? 1 : $clog2(RST_PULSE_CYCLES);
   localparam logic [SIL_W-1:0]  SIL_MAX   = SIL_W'(TIMEOUT_CYCLES);
   localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(RST_PULSE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SYNC  = 2'd1,
      ST_PULSE = 2'd2,
      ST_LOAD  = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      KIND_ENTRY = 2'd0,
      KIND_EXIT  = 2'd1,
      KIND_SW    = 2'd2
   } kind_t;

   state_t              r_state, r_ret, w_state_nx, w_ret_nx;
   kind_t               r_kind, w_kind_nx;
   logic [PCNT_W-1:0]   r_pcnt, w_pcnt_nx;
   logic [SIL_W-1:0]    r_sil, w_sil_nx;
   logic [31:0]         r_byte_cnt, w_byte_cnt_nx;
   logic [2:0]          r_cause, w_cause_nx, w_cause_set, w_cause_clr;
   logic                r_en, w_en_nx;
   logic                r_ack, w_ack_nx;
   logic [31:0]         r_dat, w_dat_nx, w_rd_dat;
   logic                r_reset_n, w_reset_n_nx;
   logic                r_boot, w_boot_nx;
   logic                w_entry;
   logic                w_req, w_wr0, w_cause_wr, w_ctrl_wr, w_sw_rst;
   logic                w_unused;

   // Bus decode: writes land on the ack cycle, only byte lane 0 carries control bits.
   assign w_req      = wb_cyc_i & wb_stb_i;
   assign w_wr0      = r_ack & w_req & wb_we_i & wb_sel_i[0];
   assign w_cause_wr = w_wr0 & (wb_adr_i[3:2] == 2'd0);
   assign w_ctrl_wr  = w_wr0 & (wb_adr_i[3:2] == 2'd2);
   assign w_sw_rst   = w_ctrl_wr & wb_dat_i[0] & (r_state != ST_PULSE);
   assign w_unused   = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:3], wb_sel_i[3:1]};

   assign wb_stall_o  = 1'b0;
   assign wb_err_o    = 1'b0;
   assign wb_ack_o    = r_ack;
   assign wb_dat_o    = r_dat;
   assign reset_o     = r_reset_n;
   assign boot_mode_o = r_boot;
   assign state_o     = r_state;

   // Read mux over the four-word register map.
   always_comb begin
      w_rd_dat = 32'd0;
      case (wb_adr_i[3:2])
         2'd0:    w_rd_dat = {29'd0, r_cause};
         2'd1:    w_rd_dat = r_byte_cnt;
         2'd2:    w_rd_dat = {30'd0, r_en, 1'b0};
         2'd3:    w_rd_dat = {29'd0, r_boot, r_state};
         default: w_rd_dat = 32'd0;
      endcase
   end

   // Next-state logic: sequence detection, pulse timing, load-window silence timeout.
   always_comb begin
      w_state_nx  = r_state;
      w_ret_nx    = r_ret;
      w_kind_nx   = r_kind;
      w_pcnt_nx   = r_pcnt;
      w_sil_nx    = r_sil;
      w_cause_set = 3'b000;
      w_entry     = 1'b0;
      if (w_sw_rst) begin
         // Software reset outranks any UART event seen in the same cycle.
         w_state_nx  = ST_PULSE;
         w_kind_nx   = KIND_SW;
         w_ret_nx    = ST_IDLE;
         w_pcnt_nx   = {PCNT_W{1'b0}};
         w_cause_set = 3'b100;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (uart_rx_valid && (uart_rx_byte == SYNC_CHAR) && r_en) begin
                  w_state_nx = ST_SYNC;
               end else begin
                  w_state_nx = ST_IDLE;
               end
            end
            ST_SYNC: begin
               if (!uart_rx_valid) begin
                  w_state_nx = ST_SYNC;
               end else if (uart_rx_byte == CMD_CHAR) begin
                  w_state_nx  = ST_PULSE;
                  w_kind_nx   = KIND_ENTRY;
                  w_ret_nx    = ST_LOAD;
                  w_pcnt_nx   = {PCNT_W{1'b0}};
                  w_cause_set = 3'b001;
                  w_entry     = 1'b1;
               end else if (uart_rx_byte == FILL_CHAR) begin
                  w_state_nx = ST_SYNC;
               end else begin
                  w_state_nx = ST_IDLE;
               end
            end
            ST_PULSE: begin
               if (r_pcnt == PCNT_LAST) begin
                  w_state_nx = r_ret;
                  w_pcnt_nx  = {PCNT_W{1'b0}};
                  w_sil_nx   = {SIL_W{1'b0}};
               end else begin
                  w_pcnt_nx = r_pcnt + PCNT_W'(1);
               end
            end
            ST_LOAD: begin
               if (uart_rx_valid) begin
                  w_sil_nx = {SIL_W{1'b0}};
               end else if (r_sil == SIL_MAX) begin
                  w_state_nx  = ST_PULSE;
                  w_kind_nx   = KIND_EXIT;
                  w_ret_nx    = ST_IDLE;
                  w_pcnt_nx   = {PCNT_W{1'b0}};
                  w_cause_set = 3'b010;
               end else begin
                  w_sil_nx = r_sil + SIL_W'(1);
               end
            end
            default: begin
               w_state_nx = ST_IDLE;
            end
         endcase
      end
   end

   // Register-side next values: byte counter, sticky cause, enable, bus response, outputs.
   always_comb begin
      w_byte_cnt_nx = r_byte_cnt;
      if (w_entry) begin
         w_byte_cnt_nx = 32'd0;
      end else if ((r_state == ST_LOAD) && uart_rx_valid && (r_byte_cnt != 32'hFFFF_FFFF)) begin
         w_byte_cnt_nx = r_byte_cnt + 32'd1;
      end else begin
         w_byte_cnt_nx = r_byte_cnt;
      end
      // A cause set in the same cycle as its clear must survive.
      w_cause_clr  = w_cause_wr ? wb_dat_i[2:0] : 3'b000;
      w_cause_nx   = (r_cause & ~w_cause_clr) | w_cause_set;
      w_en_nx      = w_ctrl_wr ? wb_dat_i[1] : r_en;
      w_ack_nx     = w_req & ~r_ack;
      w_dat_nx     = w_ack_nx ? w_rd_dat : 32'd0;
      w_reset_n_nx = (w_state_nx != ST_PULSE);
      w_boot_nx    = (w_state_nx == ST_LOAD) ||
                     ((w_state_nx == ST_PULSE) && (w_kind_nx == KIND_ENTRY));
   end

   // State and register update; rst low forces reset values and releases reset_o at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= ST_IDLE;
         r_ret      <= ST_IDLE;
         r_kind     <= KIND_ENTRY;
         r_pcnt     <= {PCNT_W{1'b0}};
         r_sil      <= {SIL_W{1'b0}};
         r_byte_cnt <= 32'd0;
         r_cause    <= 3'b000;
         r_en       <= 1'b1;
         r_ack      <= 1'b0;
         r_dat      <= 32'd0;
         r_reset_n  <= 1'b1;
         r_boot     <= 1'b0;
      end else begin
         r_state    <= w_state_nx;
         r_ret      <= w_ret_nx;
         r_kind     <= w_kind_nx;
         r_pcnt     <= w_pcnt_nx;
         r_sil      <= w_sil_nx;
         r_byte_cnt <= w_byte_cnt_nx;
         r_cause    <= w_cause_nx;
         r_en       <= w_en_nx;
         r_ack      <= w_ack_nx;
         r_dat      <= w_dat_nx;
         r_reset_n  <= w_reset_n_nx;
         r_boot     <= w_boot_nx;
      end
   end

endmodule

// File: tb/tb_boot_ctrl_wb.sv
// Bench for boot_ctrl_wb: a behavioural model predicts every output each
// cycle; directed sequences pin the model with hand-computed values, then a
// randomized phase mixes UART bytes, silences and bus traffic.
`timescale 1ns/1ps
module tb_boot_ctrl_wb;
   localparam int SYS_CLK_FREQ     = 10;
   localparam int TIMEOUT_SEC      = 1;
   localparam int RST_PULSE_CYCLES = 4;
   localparam int TC               = SYS_CLK_FREQ * TIMEOUT_SEC;
   localparam logic [7:0] SYNC = 8'h2d;
   localparam logic [7:0] FILL = 8'h5f;
   localparam logic [7:0] CMD  = 8'h70;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
   logic [31:0] wb_adr_i = 32'd0, wb_dat_i = 32'd0;
   logic [3:0]  wb_sel_i = 4'd0;
   logic        uart_rx_valid = 1'b0;
   logic [7:0]  uart_rx_byte = 8'd0;
   logic        wb_ack_o, wb_stall_o, wb_err_o, reset_o, boot_mode_o;
   logic [31:0] wb_dat_o;
   logic [1:0]  state_o;

   boot_ctrl_wb #(
      .SYS_CLK_FREQ(SYS_CLK_FREQ), .TIMEOUT_SEC(TIMEOUT_SEC),
      .SYNC_CHAR(SYNC), .FILL_CHAR(FILL), .CMD_CHAR(CMD),
      .RST_PULSE_CYCLES(RST_PULSE_CYCLES)
   ) dut (
      .clk(clk), .rst(rst),
      .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
      .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
      .wb_ack_o(wb_ack_o), .wb_dat_o(wb_dat_o), .wb_stall_o(wb_stall_o),
      .wb_err_o(wb_err_o), .uart_rx_valid(uart_rx_valid),
      .uart_rx_byte(uart_rx_byte), .reset_o(reset_o),
      .boot_mode_o(boot_mode_o), .state_o(state_o)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // mode: 0 idle, 1 sync seen, 2 reset pulse, 3 load window
   // kind: 0 entry, 1 exit, 2 software
   int          m_mode, m_left, m_ret, m_kind, m_sil;
   logic [31:0] m_cnt, m_dat;
   logic [2:0]  m_cause;
   logic        m_en, m_ack;

   function automatic logic m_boot();
      return (m_mode == 3) || (m_mode == 2 && m_kind == 0);
   endfunction

   task automatic model_reset();
      m_mode = 0; m_left = 0; m_ret = 0; m_kind = 0; m_sil = 0;
      m_cnt = 32'd0; m_dat = 32'd0; m_cause = 3'd0; m_en = 1'b1; m_ack = 1'b0;
   endtask

   task automatic start_pulse(input int kind, input int ret);
      m_mode = 2; m_left = RST_PULSE_CYCLES; m_kind = kind; m_ret = ret;
   endtask

   task automatic model_step();
      logic req, wr0, sw;
      logic [1:0] a;
      logic [31:0] rd, cnt_n;
      logic [2:0] set_b, clr_b;
      logic en_n;
      req = wb_cyc_i && wb_stb_i;
      a   = wb_adr_i[3:2];
      wr0 = m_ack && req && wb_we_i && wb_sel_i[0];
      case (a)
         2'd0:    rd = {29'd0, m_cause};
         2'd1:    rd = m_cnt;
         2'd2:    rd = {30'd0, m_en, 1'b0};
         default: rd = {29'd0, m_boot(), 2'(m_mode)};
      endcase
      set_b = 3'd0;
      clr_b = (wr0 && a == 2'd0) ? wb_dat_i[2:0] : 3'd0;
      cnt_n = m_cnt;
      if (m_mode == 3 && uart_rx_valid && m_cnt != 32'hFFFF_FFFF) cnt_n = m_cnt + 32'd1;
      en_n = (wr0 && a == 2'd2) ? wb_dat_i[1] : m_en;
      sw   = wr0 && a == 2'd2 && wb_dat_i[0] && m_mode != 2;
      if (sw) begin
         start_pulse(2, 0);
         set_b[2] = 1'b1;
      end else begin
         case (m_mode)
            0: if (uart_rx_valid && uart_rx_byte == SYNC && m_en) m_mode = 1;
            1: if (uart_rx_valid) begin
                  if (uart_rx_byte == CMD) begin
                     start_pulse(0, 3);
                     set_b[0] = 1'b1;
                     cnt_n = 32'd0;
                  end else if (uart_rx_byte != FILL) begin
                     m_mode = 0;
                  end
               end
            2: begin
                  m_left--;
                  if (m_left == 0) begin
                     m_mode = m_ret;
                     m_sil = 0;
                  end
               end
            default: begin
                  if (uart_rx_valid) m_sil = 0;
                  else if (m_sil == TC) begin
                     start_pulse(1, 0);
                     set_b[1] = 1'b1;
                  end else m_sil++;
               end
         endcase
      end
      m_cnt   = cnt_n;
      m_en    = en_n;
      m_cause = (m_cause & ~clr_b) | set_b;
      m_dat   = (req && !m_ack) ? rd : 32'd0;
      m_ack   = req && !m_ack;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) model_reset();
         else model_step();
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      forever begin
         @(negedge clk);
         chk("reset_o",     {31'd0, reset_o},     {31'd0, (m_mode != 2)});
         chk("boot_mode_o", {31'd0, boot_mode_o}, {31'd0, m_boot()});
         chk("state_o",     {30'd0, state_o},     32'(m_mode));
         chk("wb_ack_o",    {31'd0, wb_ack_o},    {31'd0, m_ack});
         chk("wb_dat_o",    wb_dat_o,             m_dat);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      tick();
      uart_rx_valid = 1'b1;
      uart_rx_byte  = b;
      tick();
      uart_rx_valid = 1'b0;
   endtask

   task automatic wb_xfer(input logic we, input logic [1:0] a, input logic [31:0] dat,
                          output logic [31:0] rdat);
      int waited;
      tick();
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
      wb_adr_i = ($urandom & 32'hFFFF_FFF3) | {28'd0, a, 2'b00};
      wb_dat_i = dat; wb_sel_i = 4'hF;
      tick();
      waited = 0;
      while (!wb_ack_o && waited < 8) begin
         tick();
         waited++;
      end
      chk("wb_ack_seen", {31'd0, wb_ack_o}, 32'd1);
      rdat = wb_dat_o;
      tick();
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
   endtask

   task automatic wb_wr(input logic [1:0] a, input logic [31:0] dat);
      logic [31:0] junk;
      wb_xfer(1'b1, a, dat, junk);
   endtask

   task automatic wb_rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
      logic [31:0] d;
      wb_xfer(1'b0, a, 32'd0, d);
      chk(name, d, exp);
   endtask

   // Counts reset_o low samples (at falling clock edges) of the next pulse.
   task automatic measure_pulse(input int bound, output int lows);
      lows = 0;
      @(negedge clk);
      for (int n = 0; n < bound && reset_o; n++) @(negedge clk);
      for (int n = 0; n < bound && !reset_o; n++) begin
         lows++;
         @(negedge clk);
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int lows;
      int bus_left;
      int quiet;
      repeat (3) tick();
      chk("rst_reset_o", {31'd0, reset_o}, 32'd1);
      chk("rst_state", {30'd0, state_o}, 32'd0);
      rst = 1'b1;
      wb_rd_chk("rst_cause", 2'd0, 32'd0);
      wb_rd_chk("rst_count", 2'd1, 32'd0);
      wb_rd_chk("rst_ctrl", 2'd2, 32'd2);
      wb_rd_chk("rst_status", 2'd3, 32'd0);

      // Entry sequence with repeated fill characters.
      send_byte(SYNC); send_byte(FILL); send_byte(FILL); send_byte(CMD);
      measure_pulse(20, lows);
      chk("entry_pulse_len", 32'(lows), 32'd4);
      chk("entry_state", {30'd0, state_o}, 32'd3);
      chk("entry_boot", {31'd0, boot_mode_o}, 32'd1);
      wb_rd_chk("entry_cause", 2'd0, 32'd1);

      // Three bytes in the load window, then silence until exit.
      for (int k = 0; k < 3; k++) begin
         repeat (4) tick();
         send_byte(8'($urandom));
      end
      measure_pulse(30, lows);
      chk("exit_pulse_len", 32'(lows), 32'd4);
      chk("exit_state", {30'd0, state_o}, 32'd0);
      wb_rd_chk("exit_count", 2'd1, 32'd3);
      wb_rd_chk("exit_cause", 2'd0, 32'd3);

      // Broken sequence and a lone command byte do nothing.
      send_byte(SYNC);
      chk("sync_state", {30'd0, state_o}, 32'd1);
      send_byte(8'h41);
      chk("abort_state", {30'd0, state_o}, 32'd0);
      send_byte(CMD);
      measure_pulse(12, lows);
      chk("lone_cmd_no_pulse", 32'(lows), 32'd0);

      // Software reset during load.
      send_byte(SYNC); send_byte(CMD);
      measure_pulse(20, lows);
      send_byte(8'h11);
      wb_wr(2'd2, 32'd3);
      measure_pulse(10, lows);
      chk("sw_pulse_len", 32'(lows), 32'd4);
      chk("sw_state", {30'd0, state_o}, 32'd0);
      chk("sw_boot", {31'd0, boot_mode_o}, 32'd0);
      wb_rd_chk("sw_cause", 2'd0, 32'd7);
      wb_wr(2'd0, 32'd7);
      wb_rd_chk("cause_cleared", 2'd0, 32'd0);

      // Detection disabled, then re-enabled.
      wb_wr(2'd2, 32'd0);
      wb_rd_chk("ctrl_dis", 2'd2, 32'd0);
      send_byte(SYNC); send_byte(CMD);
      measure_pulse(12, lows);
      chk("dis_no_pulse", 32'(lows), 32'd0);
      chk("dis_state", {30'd0, state_o}, 32'd0);
      wb_wr(2'd2, 32'd2);
      wb_rd_chk("ctrl_en", 2'd2, 32'd2);
      send_byte(SYNC); send_byte(CMD);
      chk("pulse_before_rst", {31'd0, reset_o}, 32'd0);

      // Asynchronous reset in the middle of the pulse.
      rst = 1'b0;
      #1;
      chk("async_reset_o", {31'd0, reset_o}, 32'd1);
      chk("async_state", {30'd0, state_o}, 32'd0);
      chk("async_boot", {31'd0, boot_mode_o}, 32'd0);
      repeat (2) tick();
      rst = 1'b1;
      wb_rd_chk("post_rst_cause", 2'd0, 32'd0);
      wb_rd_chk("post_rst_count", 2'd1, 32'd0);
      wb_rd_chk("post_rst_ctrl", 2'd2, 32'd2);
      wb_rd_chk("post_rst_status", 2'd3, 32'd0);

      // Randomized traffic checked against the model every cycle.
      bus_left = 0;
      quiet = 0;
      for (int i = 0; i < 3000; i++) begin
         tick();
         if (quiet > 0) begin
            quiet--;
            uart_rx_valid = 1'b0;
         end else begin
            if ($urandom_range(0, 40) == 0) quiet = $urandom_range(8, 20);
            uart_rx_valid = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 5))
               0, 1:    uart_rx_byte = SYNC;
               2:       uart_rx_byte = FILL;
               3:       uart_rx_byte = CMD;
               default: uart_rx_byte = 8'($urandom);
            endcase
         end
         if (bus_left > 0) begin
            bus_left--;
            if (bus_left == 0) begin
               wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
            end
         end else if ($urandom_range(0, 15) == 0) begin
            wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
            wb_we_i  = 1'($urandom_range(0, 1));
            wb_adr_i = $urandom;
            wb_dat_i = $urandom;
            if ($urandom_range(0, 3) != 0) wb_dat_i[1] = 1'b1;
            wb_sel_i = 4'($urandom);
            bus_left = 2;
         end
      end
      uart_rx_valid = 1'b0;
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
      repeat (5) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/boot_ctrl_wb.md
Name: boot_ctrl_wb

Overview:
Wishbone-slave boot/reset controller that watches the UART receive byte stream for a sync/command sequence. On a match it drives a timed reset pulse to the core, enters a load window that stays open while bytes keep arriving, then issues a closing reset pulse. Software can request a core reset and can read the reset cause and the load byte count. It sits between the UART RX and the core reset/boot-mode inputs, mapped on the peripheral Wishbone bus.

Parameters:
SYS_CLK_FREQ, 80000000, clk frequency in Hz
TIMEOUT_SEC, 2, load-window silence timeout in seconds; TIMEOUT_CYCLES = TIMEOUT_SEC*SYS_CLK_FREQ
SYNC_CHAR, 8'h2d, first byte of the sequence
FILL_CHAR, 8'h5f, byte that is allowed to repeat between sync and cmd
CMD_CHAR, 8'h70, command byte that triggers load entry
RST_PULSE_CYCLES, 16, reset_o low duration in cycles (>=1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
wb_cyc_i  in  1  bus cycle
wb_stb_i  in  1  strobe
wb_we_i  in  1  write enable
wb_adr_i  in  32  byte address; only [3:2] decoded
wb_dat_i  in  32  write data
wb_sel_i  in  4  byte selects
wb_ack_o  out  1  acknowledge
wb_dat_o  out  32  read data
wb_stall_o  out  1  constant 0
wb_err_o  out  1  constant 0
uart_rx_valid  in  1  one-cycle pulse: uart_rx_byte valid
uart_rx_byte  in  8  received byte
reset_o  out  1  active-low core reset
boot_mode_o  out  1  1 = core boots into loader
state_o  out  2  FSM state encoding for LEDs

Behaviour:
- Reset values: reset_o=1, boot_mode_o=0, state_o=IDLE(0), wb_ack_o=0, CAUSE=0, BYTE_COUNT=0, CTRL.EN=1, counters=0.
- FSM states: IDLE=0, SYNC=1, PULSE=2, LOAD=3. PULSE holds a return register ret and a kind register (ENTRY/EXIT/SW).
- IDLE: on valid with SYNC_CHAR and CTRL.EN=1 -> SYNC.
- SYNC: valid with CMD_CHAR -> PULSE(kind ENTRY, ret LOAD); valid with FILL_CHAR -> stay; any other valid byte -> IDLE; no valid -> stay.
- PULSE: reset_o=0 for exactly RST_PULSE_CYCLES consecutive cycles, starting the cycle after the triggering event, then -> ret with reset_o=1. UART bytes are ignored in PULSE.
- LOAD: silence counter is cleared on entry and on every valid byte, and increments otherwise. When it equals TIMEOUT_CYCLES with no valid byte in that cycle -> PULSE(kind EXIT, ret IDLE). A valid byte in that same cycle clears the counter and LOAD continues.
- BYTE_COUNT: cleared on an ENTRY trigger. Increments on each valid byte while in LOAD and saturates at 32'hFFFFFFFF. Held after the exit.
- boot_mode_o=1 during an ENTRY pulse and in LOAD; 0 otherwise.
- SW reset: a write with CTRL bit0=1 and sel[0]=1, accepted in IDLE/SYNC/LOAD -> PULSE(kind SW, ret IDLE). This aborts any load; SW wins over a same-cycle UART event. Ignored while in PULSE. CTRL bit0 always reads 0.
- CAUSE bits are set on the PULSE trigger cycle: bit0 ENTRY, bit1 EXIT (timeout), bit2 SW. They are sticky and write-1-to-clear (sel[0]); a set wins over a same-cycle clear.
- Register map (adr[3:2]):
  - 0 CAUSE, RW1C
  - 1 BYTE_COUNT, RO
  - 2 CTRL: bit0 SWRST (WO, self-clearing), bit1 EN (RW)
  - 3 STATUS: [1:0] state, [2] boot_mode_o, RO
  - Writes to RO registers are ignored. Unused bits read 0.
- Wishbone: wb_ack_o=1 exactly one cycle after cyc&stb, then 0 for one cycle (no back-to-back acks on a held strobe). wb_dat_o is valid with ack and is 0 otherwise. The write takes effect on the ack cycle.
- Reset mid-operation (rst low): all state returns to reset values immediately, and reset_o deasserts asynchronously.

Test Plan:
(Bench uses SYS_CLK_FREQ=10, TIMEOUT_SEC=1, RST_PULSE_CYCLES=4.)
- Bytes 2d,5f,5f,70 -> reset_o low for exactly 4 cycles; then state=3, boot_mode_o=1, CAUSE read=1.
- In LOAD, send 3 bytes 5 cycles apart, then silence -> BYTE_COUNT=3; EXIT pulse 4 cycles low after 10 silent cycles; state=0, CAUSE=3.
- Bytes 2d,41 -> back to IDLE with no pulse; then 70 alone -> no pulse.
- Write CTRL=2'b11 during LOAD -> 4-cycle pulse, state=0, CAUSE bit2 set, boot_mode_o=0. Write CAUSE=7 -> reads 0.
- Write CTRL=0 (EN=0), then send 2d,70 -> no pulse and state stays 0. Write CTRL=2 restores detection.
- Assert rst during a PULSE -> reset_o=1 immediately; all registers read reset values; state=0.
